// File: rtl/apb_reg_completer_if.sv
// APB3 bus bundle between a requester and the register completer.
// Clock and reset travel as plain ports beside it.
interface apb_reg_completer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic [2:0]            pprot;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_reg_completer.sv
// APB3 completer with ID, cycle counter, W1C status and scratch registers.
// Inserts WAIT_STATES access cycles and flags protocol violations via irq.
module apb_reg_completer #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic pclk,
    input  logic preset,
    apb_reg_completer_if.slave bus,
    output logic irq
);
    localparam int IW = $clog2(NUM_REGS);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic                  wr_q, wr_n;
    logic                  err_q, err_n;
    logic [3:0]            cnt_q, cnt_n;
    logic [31:0]           cycles;
    logic [1:0]            status, status_n;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [IW-1:0]         idx;
    logic                  done;
    logic                  proto_set;
    logic                  commit;
    logic                  unused;

    assign unused = ^bus.pprot;
    assign idx    = addr_q[2 +: IW];

    function automatic logic dec_err(
        input logic [ADDR_WIDTH-1:0] a,
        input logic                  w
    );
        logic [IW-1:0] i;
        i = a[2 +: IW];
        dec_err = (a[1:0] != 2'b00)
               || ((a >> (IW + 2)) != '0)
               || (w && (i == IW'(0) || i == IW'(1)));
    endfunction

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state  <= IDLE;
            addr_q <= '0;
            wr_q   <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            state  <= state_n;
            addr_q <= addr_n;
            wr_q   <= wr_n;
            err_q  <= err_n;
            cnt_q  <= cnt_n;
        end
    end

    // Latched setup values stay authoritative for the whole access phase.
    always_comb begin
        state_n   = state;
        addr_n    = addr_q;
        wr_n      = wr_q;
        err_n     = err_q;
        cnt_n     = cnt_q;
        proto_set = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.psel && !bus.penable) begin
                    addr_n  = bus.paddr;
                    wr_n    = bus.pwrite;
                    err_n   = dec_err(bus.paddr, bus.pwrite);
                    cnt_n   = 4'(WAIT_STATES);
                    state_n = ACCESS;
                end else if (bus.psel && bus.penable) begin
                    proto_set = 1'b1;
                end
            end
            ACCESS: begin
                if (!bus.psel) begin
                    proto_set = 1'b1;
                    state_n   = IDLE;
                end else begin
                    if (bus.paddr != addr_q || bus.pwrite != wr_q)
                        proto_set = 1'b1;
                    if (!bus.penable) begin
                        proto_set = 1'b1;
                    end else if (cnt_q != 4'd0) begin
                        cnt_n = cnt_q - 4'd1;
                    end else begin
                        done    = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.pready  = done;
    assign bus.pslverr = done && err_q;
    assign commit      = done && wr_q && !err_q;

    always_comb begin
        bus.prdata = '0;
        if (done && !wr_q && !err_q) begin
            case (idx)
                IW'(0):  bus.prdata = DATA_WIDTH'(ID_VALUE);
                IW'(1):  bus.prdata = DATA_WIDTH'(cycles);
                IW'(2):  bus.prdata = DATA_WIDTH'(status);
                default: bus.prdata = regs[idx];
            endcase
        end
    end

    // Hardware sets are applied after the W1C clear so they win.
    always_comb begin
        status_n = status;
        if (commit && idx == IW'(2))
            status_n = status & ~bus.pwdata[1:0];
        if (proto_set)
            status_n[0] = 1'b1;
        if (done && err_q)
            status_n[1] = 1'b1;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            cycles <= '0;
            status <= '0;
        end else begin
            cycles <= cycles + 32'd1;
            status <= status_n;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (commit && idx >= IW'(3)) begin
            regs[idx] <= bus.pwdata;
        end
    end

    assign irq = status[0] | status[1];
endmodule

// File: tb/tb_apb_reg_completer.sv
// Randomised scoreboard bench for apb_reg_completer.
// Driver pushes expected responses; a negedge monitor pops and compares.
module tb_apb_reg_completer;
    localparam int          AW  = 32;
    localparam int          DW  = 32;
    localparam int          NR  = 16;
    localparam int          WS  = 2;
    localparam logic [31:0] IDV = 32'hA5B0_0001;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        is_cyc;
    } exp_t;

    logic pclk = 1'b0;
    logic preset = 1'b1;
    logic irq;

    apb_reg_completer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    apb_reg_completer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
        .WAIT_STATES(WS), .ID_VALUE(IDV)
    ) dut (
        .pclk(pclk),
        .preset(preset),
        .bus(bus),
        .irq(irq)
    );

    always #5 pclk = ~pclk;

    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] mem [NR];
    logic [1:0]  st;
    logic [31:0] tb_cyc;
    logic [31:0] last_cyc = '0;
    int          acc = 0;

    // Reference clock count: number of clock edges seen since reset.
    always @(posedge pclk or posedge preset)
        if (preset) tb_cyc <= '0;
        else tb_cyc <= tb_cyc + 32'd1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge pclk) begin : mon
        exp_t        e;
        logic [31:0] ex;
        if (!preset && bus.psel && bus.penable) acc++;
        if (bus.pready) begin
            if (q.size() == 0) begin
                chk("unexpected_pready", 32'd1, 32'd0);
            end else begin
                e  = q.pop_front();
                ex = e.is_cyc ? tb_cyc : e.rdata;
                chk("prdata", bus.prdata, ex);
                chk("pslverr", {31'b0, bus.pslverr}, {31'b0, e.err});
                chk("latency", 32'(acc), 32'(WS + 1));
                if (e.is_cyc) last_cyc = bus.prdata;
            end
            acc = 0;
        end else begin
            if (bus.psel)
                chk("wait_outputs", bus.prdata | {31'b0, bus.pslverr}, 32'd0);
            if (!bus.psel) acc = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic xfer(input logic [31:0] a, input logic w,
                        input logic [31:0] d, input bit chg = 1'b0);
        exp_t        e;
        int          wi;
        logic        err;
        bit          ok;
        wi  = int'(a >> 2);
        err = (a % 4 != 0) || (a >= NR * 4) || (w && wi < 2);
        e.err    = err;
        e.is_cyc = 1'b0;
        e.rdata  = '0;
        if (!err && !w) begin
            if (wi == 0) e.rdata = IDV;
            else if (wi == 1) e.is_cyc = 1'b1;
            else if (wi == 2) e.rdata = {30'b0, st};
            else e.rdata = mem[wi];
        end
        if (!err && w) begin
            if (wi == 2) st = st & ~d[1:0];
            else mem[wi] = d;
        end
        if (chg) st[0] = 1'b1;
        if (err) st[1] = 1'b1;
        q.push_back(e);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.paddr   = a;
        bus.pwrite  = w;
        bus.pwdata  = d;
        @(posedge pclk);
        #1;
        bus.penable = 1'b1;
        if (chg) bus.paddr = a ^ 32'd4;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            if (bus.pready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("pready_timeout", 32'd0, 32'd1);
        @(posedge pclk);
        #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mem[i] = '0;
        st = '0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] first;
        logic [31:0] a;
        int          sel;
        model_reset();
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = '0;
        bus.pwdata  = '0;
        bus.pprot   = 3'b010;
        #12;
        chk("rst_pready", {31'b0, bus.pready}, 32'd0);
        chk("rst_pslverr", {31'b0, bus.pslverr}, 32'd0);
        chk("rst_prdata", bus.prdata, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        @(negedge pclk);
        preset = 1'b0;
        @(posedge pclk);
        #1;

        // Basic scratch write/read and ID read
        xfer(32'h0C, 1'b1, 32'hDEAD_BEEF);
        xfer(32'h0C, 1'b0, '0);
        xfer(32'h00, 1'b0, '0);

        // Decode errors, STATUS and irq
        xfer(32'h04, 1'b1, 32'h1);
        xfer(32'h06, 1'b0, '0);
        xfer(32'h40, 1'b0, '0);
        xfer(32'h04, 1'b0, '0);
        xfer(32'h08, 1'b0, '0);
        chk("irq_after_err", {31'b0, irq}, 32'd1);
        xfer(32'h08, 1'b1, 32'h2);
        chk("irq_cleared", {31'b0, irq}, {31'b0, |st});
        xfer(32'h08, 1'b0, '0);

        // CYCLES reads with setups 10 clocks apart
        xfer(32'h04, 1'b0, '0);
        first = last_cyc;
        idle(10 - (WS + 2));
        xfer(32'h04, 1'b0, '0);
        chk("cyc_delta", last_cyc - first, 32'd10);

        // Access without setup from IDLE
        xfer(32'h14, 1'b1, 32'h1111_2222);
        bus.psel    = 1'b1;
        bus.penable = 1'b1;
        bus.paddr   = 32'h14;
        bus.pwrite  = 1'b0;
        @(posedge pclk);
        #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        st[0] = 1'b1;
        idle(1);
        chk("irq_proto", {31'b0, irq}, 32'd1);
        xfer(32'h08, 1'b0, '0);
        xfer(32'h08, 1'b1, 32'h3);

        // Master abort during the wait phase of a write
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.paddr   = 32'h14;
        bus.pwrite  = 1'b1;
        bus.pwdata  = 32'h0BAD_0BAD;
        @(posedge pclk);
        #1;
        bus.penable = 1'b1;
        @(posedge pclk);
        #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        st[0] = 1'b1;
        idle(2);
        chk("irq_abort", {31'b0, irq}, 32'd1);
        xfer(32'h14, 1'b0, '0);
        xfer(32'h08, 1'b0, '0);

        // Address change mid-access; set beats W1C clear on STATUS
        xfer(32'h18, 1'b1, 32'hCAFE_F00D);
        xfer(32'h08, 1'b1, 32'h3);
        xfer(32'h18, 1'b0, '0, 1'b1);
        xfer(32'h08, 1'b1, 32'h1, 1'b1);
        xfer(32'h08, 1'b0, '0);

        // Randomised traffic
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)
                a = 32'($urandom_range(0, NR - 1) * 4 + $urandom_range(1, 3));
            else if (sel == 1)
                a = 32'h40 + 32'($urandom_range(0, 63) * 4);
            else if (sel == 2)
                a = 32'h8000_0000 | 32'($urandom_range(0, NR - 1) * 4);
            else
                a = 32'($urandom_range(0, NR - 1) * 4);
            xfer(a, 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        chk("irq_random", {31'b0, irq}, {31'b0, |st});

        // Reset in the wait phase of a write
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.paddr   = 32'h10;
        bus.pwrite  = 1'b1;
        bus.pwdata  = 32'h1234_5678;
        @(posedge pclk);
        #1;
        bus.penable = 1'b1;
        @(negedge pclk);
        preset = 1'b1;
        #1;
        chk("mid_rst_pready", {31'b0, bus.pready}, 32'd0);
        chk("mid_rst_pslverr", {31'b0, bus.pslverr}, 32'd0);
        chk("mid_rst_prdata", bus.prdata, 32'd0);
        chk("mid_rst_irq", {31'b0, irq}, 32'd0);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        model_reset();
        @(negedge pclk);
        preset = 1'b0;
        @(posedge pclk);
        #1;
        xfer(32'h10, 1'b0, '0);
        xfer(32'h08, 1'b0, '0);
        xfer(32'h0C, 1'b0, '0);

        idle(2);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
